// File: rtl/m2s_pkg.sv
// MIDI-to-synth shared definitions: status nibbles, parser state encoding and
// the voice table entry layout used by midi_voice_allocator.
package m2s_pkg;

    localparam logic [3:0] NOTE_OFF     = 4'h8;
    localparam logic [3:0] NOTE_ON      = 4'h9;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    // Widest age field needed (NUM_VOICES up to 16 -> clog2(16)+1).
    // Each allocator saturates at its own narrower limit.
    localparam int unsigned AGE_W_MAX = 5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_NOTE = 2'd1,
        ST_WAIT_VEL  = 2'd2
    } parser_state_e;

    typedef struct packed {
        logic                 active;
        logic [6:0]           note;
        logic [AGE_W_MAX-1:0] age;
    } voice_entry_t;

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser for one channel: note-on/note-off with running status.
// Ports:
//   clk, resetq          clock, synchronous active-high reset
//   rx_valid, rx_byte    incoming UART byte strobe
//   msg_valid_c          combinational: completed message on this rx_valid cycle
//   msg_is_on_c          1 = note-on with nonzero velocity, 0 = note-off
//   msg_note_c           note number of the completed message
//   msg_vel_c            velocity byte of the completed message
module midi_msg_parser
    import m2s_pkg::*;
#(
    parameter int unsigned CHANNEL = 0
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       msg_valid_c,
    output logic       msg_is_on_c,
    output logic [6:0] msg_note_c,
    output logic [7:0] msg_vel_c
);

    parser_state_e state_q, state_d;
    logic          rs_valid_q, rs_valid_d;
    logic          rs_on_q, rs_on_d;
    logic [6:0]    note_q, note_d;

    // State register
    always_ff @(posedge clk) begin
        if (resetq) begin
            state_q    <= ST_IDLE;
            rs_valid_q <= 1'b0;
            rs_on_q    <= 1'b0;
            note_q     <= '0;
        end else begin
            state_q    <= state_d;
            rs_valid_q <= rs_valid_d;
            rs_on_q    <= rs_on_d;
            note_q     <= note_d;
        end
    end

    // Next state; the message is emitted combinationally on the velocity byte
    always_comb begin
        state_d     = state_q;
        rs_valid_d  = rs_valid_q;
        rs_on_d     = rs_on_q;
        note_d      = note_q;
        msg_valid_c = 1'b0;
        msg_is_on_c = 1'b0;
        msg_note_c  = note_q;
        msg_vel_c   = rx_byte;

        // Realtime bytes fall through untouched
        if (rx_valid && (rx_byte < REALTIME_MIN)) begin
            if (rx_byte[7]) begin
                if (((rx_byte[7:4] == NOTE_OFF) || (rx_byte[7:4] == NOTE_ON)) &&
                    (rx_byte[3:0] == 4'(CHANNEL))) begin
                    rs_valid_d = 1'b1;
                    rs_on_d    = (rx_byte[7:4] == NOTE_ON);
                    state_d    = ST_WAIT_NOTE;
                end else begin
                    rs_valid_d = 1'b0;
                    rs_on_d    = 1'b0;
                    state_d    = ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rs_valid_q) begin
                            note_d  = rx_byte[6:0];
                            state_d = ST_WAIT_VEL;
                        end
                    end
                    ST_WAIT_NOTE: begin
                        note_d  = rx_byte[6:0];
                        state_d = ST_WAIT_VEL;
                    end
                    ST_WAIT_VEL: begin
                        msg_valid_c = 1'b1;
                        msg_is_on_c = rs_on_q && (rx_byte != 8'h00);
                        state_d     = ST_WAIT_NOTE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice scheduler: parses one MIDI channel and maps notes onto
// NUM_VOICES oscillators, issuing one load strobe per voice update.
// Optional feature macro: VOICE_STEAL_EN (steal the oldest voice when full;
// otherwise a note-on with all voices busy is dropped).
// Ports:
//   clk, resetq          clock, synchronous active-high reset
//   rx_valid, rx_byte    incoming UART byte strobe
//   voice_load           one-cycle strobe to voice voice_idx
//   voice_idx            target voice
//   voice_note           MIDI note number
//   voice_velocity       velocity, 0 silences the voice
//   voice_active         per-voice "holds a sounding note" flags
module midi_voice_allocator
    import m2s_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned CHANNEL    = 0
) (
    input  logic                          clk,
    input  logic                          resetq,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_byte,
    output logic                          voice_load,
    output logic [$clog2(NUM_VOICES)-1:0] voice_idx,
    output logic [7:0]                    voice_note,
    output logic [7:0]                    voice_velocity,
    output logic [NUM_VOICES-1:0]         voice_active
);

    localparam int unsigned IDX_W = $clog2(NUM_VOICES);
    localparam int unsigned AGE_W = $clog2(NUM_VOICES) + 1;
    localparam logic [AGE_W_MAX-1:0] AGE_MAX = AGE_W_MAX'((1 << AGE_W) - 1);

    logic       msg_valid_c;
    logic       msg_is_on_c;
    logic [6:0] msg_note_c;
    logic [7:0] msg_vel_c;

    midi_msg_parser #(.CHANNEL(CHANNEL)) u_parser (
        .clk         (clk),
        .resetq      (resetq),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .msg_valid_c (msg_valid_c),
        .msg_is_on_c (msg_is_on_c),
        .msg_note_c  (msg_note_c),
        .msg_vel_c   (msg_vel_c)
    );

    voice_entry_t     table_q [NUM_VOICES];
    voice_entry_t     table_d [NUM_VOICES];
    logic             load_q, load_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       note_q, note_d;
    logic [7:0]       vel_q, vel_d;

    logic             hit_c, free_c, alloc_c;
    logic [IDX_W-1:0] hit_idx_c, free_idx_c, tgt_c;
`ifdef VOICE_STEAL_EN
    logic [IDX_W-1:0]     old_idx_c;
    logic [AGE_W_MAX-1:0] old_age_c;
`endif

    // Voice table and output registers
    always_ff @(posedge clk) begin
        if (resetq) begin
            for (int i = 0; i < int'(NUM_VOICES); i++) table_q[i] <= '0;
            load_q <= 1'b0;
            idx_q  <= '0;
            note_q <= '0;
            vel_q  <= '0;
        end else begin
            table_q <= table_d;
            load_q  <= load_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            vel_q   <= vel_d;
        end
    end

    // Lookup: first voice holding the note, lowest free voice, oldest voice
    always_comb begin
        hit_c      = 1'b0;
        hit_idx_c  = '0;
        free_c     = 1'b0;
        free_idx_c = '0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (!hit_c && table_q[i].active && (table_q[i].note == msg_note_c)) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
            if (!free_c && !table_q[i].active) begin
                free_c     = 1'b1;
                free_idx_c = IDX_W'(i);
            end
        end
`ifdef VOICE_STEAL_EN
        // Strict greater-than keeps the lowest index on ties
        old_idx_c = '0;
        old_age_c = table_q[0].age;
        for (int i = 1; i < int'(NUM_VOICES); i++) begin
            if (table_q[i].age > old_age_c) begin
                old_age_c = table_q[i].age;
                old_idx_c = IDX_W'(i);
            end
        end
`endif
    end

    // Message execution
    always_comb begin
        table_d = table_q;
        load_d  = 1'b0;
        idx_d   = idx_q;
        note_d  = note_q;
        vel_d   = vel_q;
        alloc_c = 1'b0;
        tgt_c   = '0;

        if (msg_valid_c) begin
            if (msg_is_on_c) begin
                if (hit_c) begin
                    alloc_c = 1'b1;
                    tgt_c   = hit_idx_c;
                end else if (free_c) begin
                    alloc_c = 1'b1;
                    tgt_c   = free_idx_c;
                end else begin
`ifdef VOICE_STEAL_EN
                    alloc_c = 1'b1;
                    tgt_c   = old_idx_c;
`else
                    alloc_c = 1'b0;
`endif
                end
                if (alloc_c) begin
                    for (int j = 0; j < int'(NUM_VOICES); j++) begin
                        if ((IDX_W'(j) != tgt_c) && table_q[j].active &&
                            (table_q[j].age < AGE_MAX)) begin
                            table_d[j].age = table_q[j].age + AGE_W_MAX'(1);
                        end
                    end
                    table_d[tgt_c] = '{active: 1'b1, note: msg_note_c, age: '0};
                    load_d = 1'b1;
                    idx_d  = tgt_c;
                    note_d = {1'b0, msg_note_c};
                    vel_d  = msg_vel_c;
                end
            end else if (hit_c) begin
                table_d[hit_idx_c] = '0;
                load_d = 1'b1;
                idx_d  = hit_idx_c;
                note_d = {1'b0, msg_note_c};
                vel_d  = 8'h00;
            end
        end
    end

    // Output mapping
    always_comb begin
        for (int i = 0; i < int'(NUM_VOICES); i++) voice_active[i] = table_q[i].active;
    end

    assign voice_load     = load_q;
    assign voice_idx      = idx_q;
    assign voice_note     = note_q;
    assign voice_velocity = vel_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Scoreboard bench for midi_voice_allocator (NUM_VOICES = 4, CHANNEL = 0).
module tb_midi_voice_allocator;

    logic       clk = 1'b0;
    logic       resetq = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       voice_load;
    logic [1:0] voice_idx;
    logic [7:0] voice_note;
    logic [7:0] voice_velocity;
    logic [3:0] voice_active;

    midi_voice_allocator #(.NUM_VOICES(4), .CHANNEL(0)) dut (
        .clk            (clk),
        .resetq         (resetq),
        .rx_valid       (rx_valid),
        .rx_byte        (rx_byte),
        .voice_load     (voice_load),
        .voice_idx      (voice_idx),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .voice_active   (voice_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] idx;
        logic [7:0] note;
        logic [7:0] vel;
        logic [3:0] act;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every strobe is matched against the oldest expected entry
    always @(negedge clk) begin
        if (!resetq && voice_load) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe_idx_note", {voice_idx, voice_note}, -1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("voice_idx", int'(voice_idx), int'(e.idx));
                chk("voice_note", int'(voice_note), int'(e.note));
                chk("voice_velocity", int'(voice_velocity), int'(e.vel));
                chk("voice_active", int'(voice_active), int'(e.act));
            end
        end
    end

    task automatic drive(input logic [7:0] b, input bit push, input exp_t e);
        exp_t t;
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_byte  = b;
        if (push) begin
            t     = e;
            t.cyc = cyc + 1;
            q.push_back(t);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (38) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        exp_t e;
        e = '{0, 2'd0, 8'h00, 8'h00, 4'h0};
        drive(b, 1'b0, e);
    endtask

    task automatic send_exp(input logic [7:0] b, input logic [1:0] idx,
                            input logic [7:0] note, input logic [7:0] vel,
                            input logic [3:0] act);
        exp_t e;
        e = '{0, idx, note, vel, act};
        drive(b, 1'b1, e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 resetq = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetq = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 resetq = 1'b0;
        @(negedge clk);
        chk("reset_load", int'(voice_load), 0);
        chk("reset_idx_note_vel", int'({voice_idx, voice_note, voice_velocity}), 0);
        chk("reset_active", int'(voice_active), 0);

        // Note-on then running-status note-on
        send(8'h90); send(8'h3C); send_exp(8'h64, 2'd0, 8'h3C, 8'h64, 4'b0001);
        send(8'h40); send_exp(8'h50, 2'd1, 8'h40, 8'h50, 4'b0011);

        // Realtime bytes interleaved, then note-off
        do_reset();
        send(8'h90); send(8'h3C); send(8'hF8); send_exp(8'h64, 2'd0, 8'h3C, 8'h64, 4'b0001);
        send(8'h80); send(8'h3C); send(8'hF8); send_exp(8'h00, 2'd0, 8'h3C, 8'h00, 4'b0000);
        // Note-off of an unknown note
        send(8'h80); send(8'h50); send(8'h00);
        chk("unknown_off_active", int'(voice_active), 0);

        // Fill all four voices, then a fifth note-on
        do_reset();
        send(8'h90);
        send(8'h3C); send_exp(8'h64, 2'd0, 8'h3C, 8'h64, 4'b0001);
        send(8'h3E); send_exp(8'h64, 2'd1, 8'h3E, 8'h64, 4'b0011);
        send(8'h40); send_exp(8'h64, 2'd2, 8'h40, 8'h64, 4'b0111);
        send(8'h41); send_exp(8'h64, 2'd3, 8'h41, 8'h64, 4'b1111);
`ifdef VOICE_STEAL_EN
        send(8'h43); send_exp(8'h64, 2'd0, 8'h43, 8'h64, 4'b1111);
        // Next steal hits the now-oldest voice 1
        send(8'h45); send_exp(8'h64, 2'd1, 8'h45, 8'h64, 4'b1111);
`else
        send(8'h43); send(8'h64);
        chk("full_drop_active", int'(voice_active), 4'hF);
`endif
        // Note-off frees a voice, note-on by velocity 0
        send(8'h41); send_exp(8'h00, 2'd3, 8'h41, 8'h00, 4'b0111);

        // Other channel, reset mid-message, aborted message
        do_reset();
        send(8'h91); send(8'h3C); send(8'h64);
        chk("other_channel_active", int'(voice_active), 0);
        send(8'h90); send(8'h3C);
        do_reset();
        send(8'h64);
        chk("reset_mid_msg_active", int'(voice_active), 0);
        send(8'h90); send(8'h3C); send(8'hB0); send(8'h64); send(8'h3C);
        chk("abort_active", int'(voice_active), 0);

        // Retrigger same note
        send(8'h90); send(8'h3C); send_exp(8'h64, 2'd0, 8'h3C, 8'h64, 4'b0001);
        send(8'h90); send(8'h3C); send_exp(8'h20, 2'd0, 8'h3C, 8'h20, 4'b0001);

        repeat (10) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
